// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle MIPS main control FSM with memory ready handshake and wait limit
// Optional performance counters: define MC_CTRL_PERF_CNT_EN.
module mips_mc_ctrl #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_fn,
    output logic [1:0]       ext_op,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_IMMEX, S_IMMWB
    } state_t;

    localparam int WW = $clog2(WAIT_LIMIT + 2);
    localparam logic [WW-1:0] LIM_M1 = WW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    state_t        state_q, state_d;
    logic [5:0]    op_q;
    logic [WW-1:0] wait_q, wait_d;
    logic          mem_state, timeout;
    logic [2:0]    imm_fn_sel;
    logic [1:0]    ext_sel;

    // funct is decoded by the ALU control when alu_op=10, not here
    logic unused_funct;
    assign unused_funct = ^funct;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout   = (WAIT_LIMIT != 0) && mem_state && !mem_ready && (wait_q == LIM_M1);
    // Counter only survives while stalled in a memory state; any exit or re-entry clears it
    assign wait_d    = (mem_state && !mem_ready && !timeout) ? wait_q + WW'(1) : '0;

    always_comb begin
        imm_fn_sel = 3'b000;
        ext_sel    = 2'b00;
        case (op_q)
            6'h0A: imm_fn_sel = 3'b011;
            6'h0C: begin imm_fn_sel = 3'b001; ext_sel = 2'b01; end
            6'h0D: begin imm_fn_sel = 3'b010; ext_sel = 2'b01; end
            6'h0F: ext_sel = 2'b10;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) op_q <= opcode;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 2'b00;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        imm_fn      = 3'b000;
        ext_op      = 2'b00;
        illegal_op  = 1'b0;
        mem_timeout = timeout;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    6'h00:                             state_d = S_EXEC;
                    6'h23, 6'h2B:                      state_d = S_MEMADR;
                    6'h04, 6'h05:                      state_d = S_BRANCH;
                    6'h02:                             state_d = S_JUMP;
                    6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: state_d = S_IMMEX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == 6'h2B) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready || timeout) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = ((op_q == 6'h04) && zero) || ((op_q == 6'h05) && !zero);
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_en   = 1'b1;
                pc_src  = 2'b10;
                state_d = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                imm_fn    = imm_fn_sel;
                ext_op    = ext_sel;
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write = 1'b1;
                imm_fn    = imm_fn_sel;
                ext_op    = ext_sel;
                state_d   = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] instr_cnt_q, cycle_cnt_q;
    logic             retire;

    assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                    (state_q == S_JUMP) || (state_q == S_IMMWB) ||
                    ((state_q == S_MEMWR) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (retire) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`else
    assign instr_cnt = '0;
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - scoreboard bench for mips_mc_ctrl with directed per-cycle vectors
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, iord, ir_write, pc_en;
    logic [1:0]  pc_src;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic [2:0]  imm_fn;
    logic [1:0]  ext_op;
    logic        illegal_op, mem_timeout;
    logic [31:0] instr_cnt, cycle_cnt;

    mips_mc_ctrl #(.WAIT_LIMIT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_fn(imm_fn), .ext_op(ext_op),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .instr_cnt(instr_cnt),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    logic [21:0] ctl;
    assign ctl = {mem_read, mem_write, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, imm_fn, ext_op, illegal_op, mem_timeout};

    logic [21:0] q_ctl[$];
    logic [31:0] q_ic[$];
    logic [31:0] q_cc[$];
    string       q_tag[$];
    int checks = 0;
    int errors = 0;
    int exp_ic = 0;
    int exp_cc = 0;
    bit pend = 1'b0;

    logic [21:0] e_idle, e_fw, e_fr, e_fto, e_dec, e_ill, e_madr, e_mrd, e_mwb, e_mwr;
    logic [21:0] e_exe, e_awb, e_brt, e_brn, e_jmp;

    function automatic logic [21:0] cv(input logic mr, mw, io, irw, pce, input logic [1:0] pcs,
                                       input logic rw, rd, m2r, asa, input logic [1:0] asb, aop,
                                       input logic [2:0] ifn, input logic [1:0] eop,
                                       input logic ill, tmo);
        return {mr, mw, io, irw, pce, pcs, rw, rd, m2r, asa, asb, aop, ifn, eop, ill, tmo};
    endfunction

    function automatic logic [21:0] immex(input logic [2:0] f, input logic [1:0] x);
        return cv(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b11,f,x,0,0);
    endfunction

    function automatic logic [21:0] immwb(input logic [2:0] f, input logic [1:0] x);
        return cv(0,0,0,0,0,2'b00,1,0,0,0,2'b00,2'b00,f,x,0,0);
    endfunction

    // One clock cycle: drive inputs just after the edge and queue what the DUT must show
    task automatic step(input logic rst, input logic [5:0] op, input logic z, input logic mr,
                        input logic [21:0] e, input bit ret, input string tag);
        @(posedge clk);
        if (rst_n) begin
            exp_cc++;
            if (pend) exp_ic++;
        end
        #1;
        rst_n = rst; opcode = op; zero = z; mem_ready = mr; funct = 6'h20;
        if (!rst) begin exp_cc = 0; exp_ic = 0; end
        pend = ret;
        q_ctl.push_back(e);
        q_tag.push_back(tag);
`ifdef MC_CTRL_PERF_CNT_EN
        q_ic.push_back(exp_ic);
        q_cc.push_back(exp_cc);
`else
        q_ic.push_back(32'd0);
        q_cc.push_back(32'd0);
`endif
    endtask

    task automatic s(input logic [5:0] op, input logic z, input logic mr,
                     input logic [21:0] e, input bit ret, input string tag);
        step(1'b1, op, z, mr, e, ret, tag);
    endtask

    initial begin
        logic [21:0] ec;
        logic [31:0] eic, ecc;
        string       t;
        forever begin
            @(negedge clk);
            if (q_ctl.size() > 0) begin
                ec = q_ctl.pop_front(); eic = q_ic.pop_front();
                ecc = q_cc.pop_front(); t = q_tag.pop_front();
                checks += 3;
                if (ctl !== ec) begin
                    errors++;
                    $display("FAIL %s ctl got %h expected %h", t, ctl, ec);
                end
                if (instr_cnt !== eic) begin
                    errors++;
                    $display("FAIL %s instr_cnt got %0d expected %0d", t, instr_cnt, eic);
                end
                if (cycle_cnt !== ecc) begin
                    errors++;
                    $display("FAIL %s cycle_cnt got %0d expected %0d", t, cycle_cnt, ecc);
                end
            end
        end
    end

    initial begin
        e_idle = '0;
        e_fw   = cv(1,0,0,0,0,2'b00,0,0,0,0,2'b01,2'b00,3'b000,2'b00,0,0);
        e_fr   = cv(1,0,0,1,1,2'b00,0,0,0,0,2'b01,2'b00,3'b000,2'b00,0,0);
        e_fto  = cv(1,0,0,0,0,2'b00,0,0,0,0,2'b01,2'b00,3'b000,2'b00,0,1);
        e_dec  = cv(0,0,0,0,0,2'b00,0,0,0,0,2'b11,2'b00,3'b000,2'b00,0,0);
        e_ill  = cv(0,0,0,0,0,2'b00,0,0,0,0,2'b11,2'b00,3'b000,2'b00,1,0);
        e_madr = cv(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00,3'b000,2'b00,0,0);
        e_mrd  = cv(1,0,1,0,0,2'b00,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0);
        e_mwb  = cv(0,0,0,0,0,2'b00,1,0,1,0,2'b00,2'b00,3'b000,2'b00,0,0);
        e_mwr  = cv(0,1,1,0,0,2'b00,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0);
        e_exe  = cv(0,0,0,0,0,2'b00,0,0,0,1,2'b00,2'b10,3'b000,2'b00,0,0);
        e_awb  = cv(0,0,0,0,0,2'b00,1,1,0,0,2'b00,2'b00,3'b000,2'b00,0,0);
        e_brt  = cv(0,0,0,0,1,2'b01,0,0,0,1,2'b00,2'b01,3'b000,2'b00,0,0);
        e_brn  = cv(0,0,0,0,0,2'b01,0,0,0,1,2'b00,2'b01,3'b000,2'b00,0,0);
        e_jmp  = cv(0,0,0,0,1,2'b10,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0);

        step(1'b0, 6'h00, 0, 1, e_idle, 0, "reset0");
        step(1'b0, 6'h00, 0, 1, e_idle, 0, "reset1");
        s(6'h00, 0, 1, e_idle, 0, "idle");
        // R-type
        s(6'h00, 0, 1, e_fr,  0, "r_fetch");
        s(6'h00, 0, 1, e_dec, 0, "r_decode");
        s(6'h00, 0, 1, e_exe, 0, "r_exec");
        s(6'h00, 0, 1, e_awb, 1, "r_aluwb");
        // lw with three wait states in MEMRD
        s(6'h23, 0, 1, e_fr,   0, "lw_fetch");
        s(6'h23, 0, 1, e_dec,  0, "lw_decode");
        s(6'h23, 0, 1, e_madr, 0, "lw_memadr");
        for (int i = 0; i < 3; i++) s(6'h23, 0, 0, e_mrd, 0, "lw_memrd_wait");
        s(6'h23, 0, 1, e_mrd, 0, "lw_memrd_ready");
        s(6'h23, 0, 1, e_mwb, 1, "lw_memwb");
        // sw
        s(6'h2B, 0, 1, e_fr,   0, "sw_fetch");
        s(6'h2B, 0, 1, e_dec,  0, "sw_decode");
        s(6'h2B, 0, 1, e_madr, 0, "sw_memadr");
        s(6'h2B, 0, 1, e_mwr,  1, "sw_memwr");
        // beq taken, bne not taken, bne taken
        s(6'h04, 1, 1, e_fr,  0, "beq_fetch");
        s(6'h04, 1, 1, e_dec, 0, "beq_decode");
        s(6'h04, 1, 1, e_brt, 1, "beq_taken");
        s(6'h05, 1, 1, e_fr,  0, "bne_fetch");
        s(6'h05, 1, 1, e_dec, 0, "bne_decode");
        s(6'h05, 1, 1, e_brn, 1, "bne_not_taken");
        s(6'h05, 0, 1, e_fr,  0, "bne2_fetch");
        s(6'h05, 0, 1, e_dec, 0, "bne2_decode");
        s(6'h05, 0, 1, e_brt, 1, "bne_taken");
        // j
        s(6'h02, 0, 1, e_fr,  0, "j_fetch");
        s(6'h02, 0, 1, e_dec, 0, "j_decode");
        s(6'h02, 0, 1, e_jmp, 1, "j_jump");
        // andi, lui, slti
        s(6'h0C, 0, 1, e_fr,  0, "andi_fetch");
        s(6'h0C, 0, 1, e_dec, 0, "andi_decode");
        s(6'h0C, 0, 1, immex(3'b001, 2'b01), 0, "andi_immex");
        s(6'h0C, 0, 1, immwb(3'b001, 2'b01), 1, "andi_immwb");
        s(6'h0F, 0, 1, e_fr,  0, "lui_fetch");
        s(6'h0F, 0, 1, e_dec, 0, "lui_decode");
        s(6'h0F, 0, 1, immex(3'b000, 2'b10), 0, "lui_immex");
        s(6'h0F, 0, 1, immwb(3'b000, 2'b10), 1, "lui_immwb");
        s(6'h0A, 0, 1, e_fr,  0, "slti_fetch");
        s(6'h0A, 0, 1, e_dec, 0, "slti_decode");
        s(6'h0A, 0, 1, immex(3'b011, 2'b00), 0, "slti_immex");
        s(6'h0A, 0, 1, immwb(3'b011, 2'b00), 1, "slti_immwb");
        // illegal opcode
        s(6'h3F, 0, 1, e_fr,  0, "ill_fetch");
        s(6'h3F, 0, 1, e_ill, 0, "ill_decode");
        // fetch timeout after four waits, re-entry restarts the wait count
        for (int i = 0; i < 3; i++) s(6'h2B, 0, 0, e_fw, 0, "to_fetch_wait");
        s(6'h2B, 0, 0, e_fto, 0, "to_fetch_timeout");
        for (int i = 0; i < 3; i++) s(6'h2B, 0, 0, e_fw, 0, "to_refetch_wait");
        s(6'h2B, 0, 1, e_fr,   0, "sw2_fetch");
        s(6'h2B, 0, 1, e_dec,  0, "sw2_decode");
        s(6'h2B, 0, 1, e_madr, 0, "sw2_memadr");
        s(6'h2B, 0, 0, e_mwr,  0, "sw2_memwr_wait");
        // asynchronous reset in the middle of MEMWR with mem_ready pending
        step(1'b0, 6'h2B, 0, 1, e_idle, 0, "async_reset");
        step(1'b0, 6'h2B, 0, 1, e_idle, 0, "reset_hold");
        s(6'h00, 0, 1, e_idle, 0, "idle2");
        s(6'h00, 0, 1, e_fr,   0, "r2_fetch");
        s(6'h00, 0, 1, e_dec,  0, "r2_decode");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q_ctl.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d expected 0", q_ctl.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS core.
- Sequences PC, instruction register, register file, ALU, memory port and immediate extender across fetch/decode/execute/memory/writeback.
- Selects the extender mode (sign, zero, lui) per opcode and stalls on a memory ready handshake.
- Sits between the instruction register's opcode/funct fields and the datapath muxes.

Parameters:
- WAIT_LIMIT, 0: max cycles to wait for mem_ready in a memory state. 0 = wait forever.
- CNT_W, 32: width of the performance counters (see Optional Feature).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26], valid from DECODE onward
- funct  in  6  instr[5:0]; forwarded through alu_op=10 only
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  0 = PC address, 1 = ALUOut address
- ir_write  out  1  load instruction register
- pc_en  out  1  write PC this cycle
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- reg_write  out  1  register file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 extended imm, 11 extended imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct decode, 11 imm_fn
- imm_fn  out  3  000 add, 001 and, 010 or, 011 slt
- ext_op  out  2  00 sign, 01 zero, 10 lui (imm<<16)
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- mem_timeout  out  1  one-cycle pulse on WAIT_LIMIT expiry
- instr_cnt  out  CNT_W  retired instructions
- cycle_cnt  out  CNT_W  cycles since reset

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, IMMEX, IMMWB.
- Reset (async, rst_n=0): state=IDLE, wait counter=0, latched opcode=0. All outputs are 0, including counters.
- IDLE: all outputs 0. Moves to FETCH on the next cycle.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - Holds while mem_ready=0.
  - On the mem_ready=1 cycle: ir_write=1, pc_en=1, pc_src=00, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, ext_op=00 (branch target into ALUOut). Latches opcode.
  - 0x00 -> EXEC
  - 0x23/0x2B -> MEMADR
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x08/0x0A/0x0C/0x0D/0x0F -> IMMEX
  - other: illegal_op=1, then FETCH
- MEMADR: alu_src_a=1, alu_src_b=10, ext_op=00, alu_op=00. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_en = (beq & zero) | (bne & ~zero).
  - Then FETCH.
- JUMP: pc_en=1, pc_src=10, then FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10, alu_op=11.
  - addi: ext_op=00, imm_fn=000
  - slti: ext_op=00, imm_fn=011
  - andi: ext_op=01, imm_fn=001
  - ori: ext_op=01, imm_fn=010
  - lui: ext_op=10, imm_fn=000, with alu_src_a=1 against $zero — rs field is 0 by ISA
  - Then IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. ext_op and imm_fn are held from IMMEX. Then FETCH.
- Unlisted outputs are 0 in every state.
- Latency in cycles, counted from entering FETCH with zero wait states:
  - R-type 4, lw 5, sw 4, beq/bne 3, j 3, imm 4, illegal 2.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR; increments each cycle mem_ready=0.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT: mem_timeout=1 for one cycle, request is dropped, next state FETCH. PC is not advanced.
  - If mem_ready and the limit coincide, mem_ready wins.
- Reset mid-operation: immediate return to IDLE with all outputs 0, regardless of pending mem_ready.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle after reset, wrapping at 2^CNT_W.
  - instr_cnt increments on the last cycle of each legal instruction: MEMWB, MEMWR with mem_ready, ALUWB, BRANCH, JUMP, IMMWB. It wraps.
  - Illegal and timed-out instructions are not counted.
- Undefined: both counters are constant 0, with no counter registers.

Test Plan:
- Reset then mem_ready=1 every cycle, opcode=0x00 -> IDLE, FETCH, DECODE, EXEC, ALUWB. reg_write=1 and reg_dst=1 in cycle 4 after FETCH entry, alu_op=10 in EXEC.
- lw (0x23) with mem_ready low 3 cycles in MEMRD -> mem_read=1, iord=1 held 4 cycles. MEMWB has mem_to_reg=1. Total 8 cycles.
- beq with zero=1, then bne with zero=1 -> pc_en=1, pc_src=01 in the first BRANCH state; pc_en=0 in the second.
- andi (0x0C), then lui (0x0F) -> ext_op=01, imm_fn=001 through IMMEX/IMMWB; ext_op=10 for lui. reg_dst=0.
- opcode=0x3F -> illegal_op pulses 1 cycle in DECODE, FETCH re-entered. instr_cnt unchanged with MC_CTRL_PERF_CNT_EN.
- WAIT_LIMIT=4, mem_ready=0 in FETCH -> mem_timeout pulse on the 4th wait cycle and pc_en never asserted. rst_n low mid-MEMWR zeroes all outputs asynchronously.
